onehot_scan_decoder: RTL and testbench

//   Parametrised registered one-hot decoder. Outputs are active-high and exactly one-hot when driving.

---
 rtl/onehot_scan_decoder_pkg.sv | 14 +
 rtl/onehot_scan_decoder_if.sv | 28 ++
 rtl/onehot_scan_decoder_dwell_counter.sv | 28 ++
 rtl/onehot_scan_decoder.sv | 161 ++++++++++++++++
 tb/tb_onehot_scan_decoder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/onehot_scan_decoder_pkg.sv
// rtl/onehot_scan_decoder_pkg.sv - shared state and mode encodings for the one-hot scan decoder
package onehot_scan_decoder_pkg;

  // FSM encodings; 2'd3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// rtl/onehot_scan_decoder_if.sv - control inputs and one-hot outputs of the scan decoder
interface onehot_scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int N_OUT   = 6,
  parameter int DWELL_W = 8
);

  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   a;
  logic               a_valid;
  logic [DWELL_W-1:0] dwell;
  logic [N_OUT-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;
  logic               err;

  modport master (
    output en, mode, a, a_valid, dwell,
    input  y, idx, wrap, err
  );

  modport slave (
    input  en, mode, a, a_valid, dwell,
    output y, idx, wrap, err
  );

endinterface

// File: rtl/onehot_scan_decoder_dwell_counter.sv
// rtl/onehot_scan_decoder_dwell_counter.sv - loadable down-counter timing each scan step
module onehot_scan_decoder_dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;

  // load wins over decrement; the counter parks at zero rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered one-hot decoder with binary decode and timed scan modes
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int N_OUT   = 6,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  onehot_scan_decoder_if.slave    bus
);

  // N_OUT held one bit wider than a so the range check never truncates
  localparam logic [SEL_W:0]   N_OUT_EXT = (SEL_W + 1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_OUT - 1);

  state_t             state_q, state_nxt;
  logic [SEL_W-1:0]   idx_q, idx_nxt;
  logic [N_OUT-1:0]   y_q, y_nxt;
  logic               wrap_q, wrap_nxt;
  logic               err_q, err_nxt;
  logic               on_q, on_nxt;

  logic               a_in_range;
  logic               scan_entry;
  logic               take_a;
  logic               blank;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  assign on_q       = |y_q;
  assign a_in_range = ({1'b0, bus.a} < N_OUT_EXT);

  onehot_scan_decoder_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (bus.dwell),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // state, index and pulse outputs all update together so y, idx and wrap stay coherent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      y_q     <= y_nxt;
      wrap_q  <= wrap_nxt;
      err_q   <= err_nxt;
    end
  end

  // next-state and next-output selection; en=0 overrides everything else
  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    on_nxt     = on_q;
    wrap_nxt   = 1'b0;
    err_nxt    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    scan_entry = 1'b0;
    take_a     = 1'b0;
    blank      = 1'b0;

    if (!bus.en) begin
      state_nxt = ST_IDLE;
      blank     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mode == MODE_SCAN) begin
            state_nxt  = ST_SCAN;
            scan_entry = 1'b1;
          end else begin
            state_nxt = ST_DECODE;
            take_a    = bus.a_valid;
          end
        end
        ST_DECODE: begin
          if (bus.mode == MODE_SCAN) begin
            state_nxt  = ST_SCAN;
            scan_entry = 1'b1;
          end else begin
            take_a = bus.a_valid;
          end
        end
        ST_SCAN: begin
          if (bus.mode == MODE_DECODE) begin
            // leaving scan blanks the outputs unless a select arrives on the same cycle
            state_nxt = ST_DECODE;
            take_a    = bus.a_valid;
            blank     = !bus.a_valid;
          end else if (cnt_zero) begin
            cnt_load = 1'b1;
            on_nxt   = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              idx_nxt = idx_q + 1'b1;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          blank     = 1'b1;
        end
      endcase
    end

    if (scan_entry) begin
      on_nxt   = 1'b1;
      idx_nxt  = '0;
      cnt_load = 1'b1;
    end

    if (take_a) begin
      if (a_in_range) begin
        on_nxt  = 1'b1;
        idx_nxt = bus.a;
      end else begin
        on_nxt  = 1'b0;
        idx_nxt = '0;
        err_nxt = 1'b1;
      end
    end

    if (blank) begin
      on_nxt  = 1'b0;
      idx_nxt = '0;
    end
  end

  // one-hot expansion of the next index; bits at or above N_OUT cannot be reached
  always_comb begin
    y_nxt = '0;
    for (int i = 0; i < N_OUT; i++) begin
      y_nxt[i] = on_nxt && (idx_nxt == SEL_W'(i));
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb/tb_onehot_scan_decoder.sv - scoreboard bench for the one-hot scan decoder
module tb_onehot_scan_decoder;

  typedef struct {
    logic [5:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       err;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  event chk_ev;

  onehot_scan_decoder_if #(.SEL_W(3), .N_OUT(6), .DWELL_W(8)) bus ();

  onehot_scan_decoder #(.SEL_W(3), .N_OUT(6), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pop_compare();
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    if (bus.y !== e.y || bus.idx !== e.idx || bus.wrap !== e.wrap || bus.err !== e.err) begin
      n_bad++;
      $display("FAIL %s: got y=%b idx=%0d wrap=%b err=%b, want y=%b idx=%0d wrap=%b err=%b",
               e.name, bus.y, bus.idx, bus.wrap, bus.err, e.y, e.idx, e.wrap, e.err);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) pop_compare();
    end
  end

  initial begin
    forever begin
      @(chk_ev);
      pop_compare();
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (!$onehot0(bus.y) || (bus.y != 6'd0 && (bus.idx >= 3'd6 || !bus.y[bus.idx]))
        || (bus.y == 6'd0 && bus.idx != 3'd0)) begin
      n_bad++;
      $display("FAIL invariant: got y=%b idx=%0d, want one-hot-or-zero with y[idx]=1", bus.y, bus.idx);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus, want finish within 100000 time units");
    $fatal(1);
  end

  task automatic step(input logic e, input logic m, input logic [2:0] av, input logic v,
                      input logic [7:0] dw, input logic chk, input logic [5:0] ey,
                      input logic [2:0] ei, input logic ew, input logic ee, input string nm);
    @(negedge clk);
    bus.en      = e;
    bus.mode    = m;
    bus.a       = av;
    bus.a_valid = v;
    bus.dwell   = dw;
    if (chk) sb.push_back('{ey, ei, ew, ee, nm});
    @(posedge clk);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.mode    = 1'b0;
    bus.a       = 3'd0;
    bus.a_valid = 1'b0;
    bus.dwell   = 8'd0;

    #1;
    sb.push_back('{6'd0, 3'd0, 1'b0, 1'b0, "reset_state"});
    ->chk_ev;
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, "idle_after_reset");
    step(1, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, "idle_to_decode");
    step(1, 0, 3, 1, 0, 1, 6'b001000, 3, 0, 0, "decode_a3");
    step(1, 0, 0, 0, 0, 1, 6'b001000, 3, 0, 0, "decode_hold");
    step(1, 0, 1, 0, 0, 1, 6'b001000, 3, 0, 0, "decode_hold_a_ignored");
    step(1, 0, 6, 1, 0, 1, 6'b000000, 0, 0, 1, "decode_a6_err");
    step(1, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, "err_one_cycle");
    step(1, 0, 5, 1, 0, 1, 6'b100000, 5, 0, 0, "decode_a5_top");
    step(1, 0, 7, 1, 0, 1, 6'b000000, 0, 0, 1, "decode_a7_err");
    step(1, 0, 0, 1, 0, 1, 6'b000001, 0, 0, 0, "decode_a0");

    step(1, 1, 0, 0, 2, 1, 6'b000001, 0, 0, 0, "scan_entry");
    for (int k = 1; k < 20; k++) begin
      logic [2:0] ei;
      ei = 3'((k / 3) % 6);
      step(1, 1, (k == 4) ? 3'd7 : 3'd0, (k == 4), 8'd2, 1, 6'd1 << ei, ei, (k == 18), 0, "scan_dwell2");
    end

    step(0, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0, "en_off");
    step(1, 1, 0, 0, 0, 1, 6'b000001, 0, 0, 0, "rescan_d0");
    for (int k = 1; k < 5; k++) begin
      step(1, 1, 0, 0, 0, 1, 6'd1 << k, 3'(k), 0, 0, "scan_dwell0");
    end
    step(0, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0, "drop_en_idx4");
    step(1, 1, 0, 0, 1, 1, 6'b000001, 0, 0, 0, "restart_scan");
    step(1, 1, 0, 0, 0, 1, 6'b000001, 0, 0, 0, "dwell_change_pending");
    step(1, 1, 0, 0, 0, 1, 6'b000010, 1, 0, 0, "dwell_reload_new");
    step(1, 1, 0, 0, 0, 1, 6'b000100, 2, 0, 0, "dwell0_step");
    step(1, 0, 4, 1, 0, 1, 6'b010000, 4, 0, 0, "scan_to_decode_av");
    step(1, 1, 0, 0, 0, 1, 6'b000001, 0, 0, 0, "decode_to_scan");
    step(1, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, "scan_to_decode_blank");
    step(1, 0, 2, 1, 0, 1, 6'b000100, 2, 0, 0, "decode_a2");
    step(0, 0, 5, 1, 0, 1, 6'b000000, 0, 0, 0, "en_beats_av");

    step(1, 1, 0, 0, 0, 1, 6'b000001, 0, 0, 0, "t5_scan0");
    step(1, 1, 0, 0, 0, 1, 6'b000010, 1, 0, 0, "t5_scan1");
    step(1, 1, 0, 0, 0, 1, 6'b000100, 2, 0, 0, "t5_scan2");
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    bus.mode    = 1'b0;
    bus.a_valid = 1'b0;
    #1;
    sb.push_back('{6'd0, 3'd0, 1'b0, 1'b0, "async_reset_midcycle"});
    ->chk_ev;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{6'd0, 3'd0, 1'b0, 1'b0, "post_reset_first_edge"});
    @(posedge clk);
    step(1, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, "post_reset_hold");

    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
